cpu_step_ctrl: RTL and testbench

//  Run/single-step clock-enable generator, directly downstream of the clock divider.

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/in_debounce.sv | 59 +++++
 rtl/cpu_step_ctrl.sv | 134 +++++++++++++
 tb/tb_cpu_step_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and default constants for the run/single-step clock-enable block.
package cpu_pkg;

    // Step-mode controller states; 2-bit encoding.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BURST    = 2'd1,
        WAIT_REL = 2'd2
    } step_state_t;

    // Default number of agreeing tick samples before a debounced level moves.
    localparam int DEB_SAMPLES_DEF = 4;
    // Default number of enable cycles issued per step press.
    localparam int STEP_CYCLES_DEF = 1;
    // Default width of the issued-enable counter.
    localparam int CNT_W_DEF       = 16;
    // Width of the burst down-counter; holds STEP_CYCLES up to 15.
    localparam int BURST_W         = 4;

endpackage

// File: rtl/in_debounce.sv
// Debouncer for one raw asynchronous input: 2-FF synchronizer, a shift
// register advanced only on the slow tick, and a level that follows the
// shift register once all of its samples agree.
module in_debounce
    import cpu_pkg::*;
#(
    parameter int DEB_SAMPLES = DEB_SAMPLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    input  logic tick,
    output logic level
);

    logic                   sync_a;
    logic                   sync_b;
    logic [DEB_SAMPLES-1:0] samples;
    logic                   all_ones;
    logic                   all_zeros;

    // Two-flop synchronizer for the raw asynchronous input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
        end else begin
            sync_a <= raw;
            sync_b <= sync_a;
        end
    end

    // Sample history advances only on a tick, so bounce faster than the tick is ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samples <= '0;
        end else if (tick) begin
            samples <= {samples[DEB_SAMPLES-2:0], sync_b};
        end
    end

    // Agreement detectors across the whole sample history.
    always_comb begin
        all_ones  = &samples;
        all_zeros = ~|samples;
    end

    // Level moves one cycle after the history becomes unanimous for the other value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level <= 1'b0;
        end else if (all_ones && !level) begin
            level <= 1'b1;
        end else if (all_zeros && level) begin
            level <= 1'b0;
        end
    end

endmodule

// File: rtl/cpu_step_ctrl.sv
// Run/single-step CPU clock-enable generator. A divider bit supplies the slow
// tick; debounced step button and run switch choose between one enable burst
// per press (step mode) and one enable per tick (run mode).
module cpu_step_ctrl
    import cpu_pkg::*;
#(
    parameter int DEB_SAMPLES = DEB_SAMPLES_DEF,
    parameter int STEP_CYCLES = STEP_CYCLES_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             div_bit,
    input  logic             btn_step,
    input  logic             sw_run,
    output logic             cpu_clk_en,
    output logic             run_mode,
    output logic             btn_level,
    output logic [CNT_W-1:0] step_count
);

    localparam logic [BURST_W-1:0] BURST_LOAD = BURST_W'(STEP_CYCLES);

    logic               div_a;
    logic               div_b;
    logic               div_d;
    logic               tick;
    logic               btn_prev;
    logic               btn_rise;
    logic               run_pulse;
    step_state_t        state;
    step_state_t        next_state;
    logic [BURST_W-1:0] burst_cnt;
    logic [BURST_W-1:0] next_burst_cnt;

    // Synchronize the divider bit and turn its rising edge into a registered one-cycle tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_a <= 1'b0;
            div_b <= 1'b0;
            div_d <= 1'b0;
            tick  <= 1'b0;
        end else begin
            div_a <= div_bit;
            div_b <= div_a;
            div_d <= div_b;
            tick  <= div_b & ~div_d;
        end
    end

    in_debounce #(.DEB_SAMPLES(DEB_SAMPLES)) u_btn_deb (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (btn_step),
        .tick  (tick),
        .level (btn_level)
    );

    in_debounce #(.DEB_SAMPLES(DEB_SAMPLES)) u_run_deb (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (sw_run),
        .tick  (tick),
        .level (run_mode)
    );

    // Remember the previous debounced button level and register the run-mode tick enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_prev  <= 1'b0;
            run_pulse <= 1'b0;
        end else begin
            btn_prev  <= btn_level;
            run_pulse <= tick & run_mode;
        end
    end

    // Step controller state and burst down-counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            burst_cnt <= '0;
        end else begin
            state     <= next_state;
            burst_cnt <= next_burst_cnt;
        end
    end

    // Next-state logic: a burst always runs to completion, even if run mode arrives mid-burst;
    // outside a burst, run mode parks the controller in IDLE.
    always_comb begin
        next_state     = state;
        next_burst_cnt = burst_cnt;
        btn_rise       = btn_level & ~btn_prev;
        case (state)
            IDLE: begin
                if (!run_mode && btn_rise) begin
                    next_state     = BURST;
                    next_burst_cnt = BURST_LOAD;
                end
            end
            BURST: begin
                next_burst_cnt = burst_cnt - 1'b1;
                if (burst_cnt <= 1) begin
                    next_state = WAIT_REL;
                end
            end
            WAIT_REL: begin
                if (run_mode || !btn_level) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state     = IDLE;
                next_burst_cnt = '0;
            end
        endcase
    end

    // Single enable line: burst and run tick are merged, so a cycle carries at most one enable.
    always_comb begin
        cpu_clk_en = (state == BURST) | run_pulse;
    end

    // Count every issued enable cycle; wraps silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_count <= '0;
        end else if (cpu_clk_en) begin
            step_count <= step_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Directed testbench for cpu_step_ctrl (DEB_SAMPLES=4, STEP_CYCLES=5, CNT_W=4).
module tb_cpu_step_ctrl;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             div_bit = 1'b0;
    logic             btn_step = 1'b0;
    logic             sw_run = 1'b0;
    logic             cpu_clk_en;
    logic             run_mode;
    logic             btn_level;
    logic [CNT_W-1:0] step_count;

    int tests = 0;
    int fails = 0;
    int en_seen = 0;
    int en_base = 0;
    int exp_total = 0;
    bit lvl_hi_seen = 1'b0;
    bit got_en = 1'b0;

    cpu_step_ctrl #(.DEB_SAMPLES(4), .STEP_CYCLES(5), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .div_bit    (div_bit),
        .btn_step   (btn_step),
        .sw_run     (sw_run),
        .cpu_clk_en (cpu_clk_en),
        .run_mode   (run_mode),
        .btn_level  (btn_level),
        .step_count (step_count)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    // observers of enable cycles and button level, sampled on the falling edge
    always @(negedge clk) begin
        if (cpu_clk_en === 1'b1) en_seen <= en_seen + 1;
        if (btn_level === 1'b1) lvl_hi_seen <= 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One slow tick: 8 cycles high, 8 low; every effect of the tick settles inside it.
    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            div_bit = 1'b1;
            repeat (8) @(negedge clk);
            div_bit = 1'b0;
            repeat (8) @(negedge clk);
        end
        #1;
    endtask

    // One fast tick: 2 cycles high, 2 low.
    task automatic tick_fast();
        div_bit = 1'b1;
        repeat (2) @(negedge clk);
        div_bit = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic check_count(input string tag);
        logic [31:0] e;
        e = exp_total % 16;
        check(tag, 32'(step_count), e);
    endtask

    initial begin
        // ---- 1: reset with toggling inputs
        #1 rst_n = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            div_bit  = $urandom_range(0, 1);
            btn_step = $urandom_range(0, 1);
            sw_run   = $urandom_range(0, 1);
            if (i % 4 == 3) begin
                #1;
                check("rst_en",    32'(cpu_clk_en), 0);
                check("rst_run",   32'(run_mode),   0);
                check("rst_btn",   32'(btn_level),  0);
                check("rst_count", 32'(step_count), 0);
            end
        end
        div_bit = 1'b0; btn_step = 1'b0; sw_run = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        #1;
        check("post_rst_en",    32'(cpu_clk_en), 0);
        check("post_rst_count", 32'(step_count), 0);
        check("post_rst_btn",   32'(btn_level),  0);

        // ---- 2: clean press
        en_base = en_seen;
        btn_step = 1'b1;
        tick_n(3);
        check("press_lvl_3tick", 32'(btn_level), 0);
        check("press_en_3tick",  32'(en_seen - en_base), 0);
        tick_n(1);
        check("press_lvl_4tick", 32'(btn_level), 1);
        check("press_en_burst",  32'(en_seen - en_base), 5);
        exp_total += 5;
        check_count("press_count");
        tick_n(22);
        check("hold_no_restep",  32'(en_seen - en_base), 5);
        btn_step = 1'b0;
        tick_n(4);
        check("release_lvl",     32'(btn_level), 0);
        check("release_no_en",   32'(en_seen - en_base), 5);

        // ---- 3: bounce
        en_base = en_seen;
        lvl_hi_seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            btn_step = ~btn_step;
            tick_n(1);
        end
        btn_step = 1'b0;
        tick_n(4);
        check("bounce_lvl_never", 32'(lvl_hi_seen), 0);
        check("bounce_no_en",     32'(en_seen - en_base), 0);
        check_count("bounce_count");

        // ---- 4: run mode
        en_base = en_seen;
        sw_run = 1'b1;
        tick_n(3);
        check("run_lvl_3tick", 32'(run_mode), 0);
        tick_n(1);
        check("run_lvl_4tick", 32'(run_mode), 1);
        check("run_en_entry",  32'(en_seen - en_base), 0);
        tick_n(8);
        check("run_en_8tick",  32'(en_seen - en_base), 8);
        exp_total += 8;
        check_count("run_count");
        // run -> step: ticks keep enabling until run_mode drops on the 4th low sample
        en_base = en_seen;
        sw_run = 1'b0;
        tick_n(4);
        check("run_exit_lvl",  32'(run_mode), 0);
        check("run_exit_en",   32'(en_seen - en_base), 4);
        exp_total += 4;
        check_count("run_exit_wrap");
        tick_n(2);
        check("step_idle_en",  32'(en_seen - en_base), 4);

        // ---- 5: run arrives mid-burst
        en_base = en_seen;
        btn_step = 1'b1;
        tick_n(1);
        sw_run = 1'b1;
        tick_n(2);
        tick_fast();
        tick_fast();
        repeat (16) @(negedge clk);
        #1;
        check("midburst_run_lvl", 32'(run_mode), 1);
        check("midburst_en_full", 32'(en_seen - en_base), 5);
        tick_n(3);
        check("midburst_run_en",  32'(en_seen - en_base), 8);
        exp_total += 8;
        check_count("midburst_count");
        en_base = en_seen;
        btn_step = 1'b0;
        sw_run = 1'b0;
        tick_n(4);
        check("mid_exit_en",      32'(en_seen - en_base), 4);
        exp_total += 4;
        tick_n(1);
        check("mid_exit_idle",    32'(en_seen - en_base), 4);
        check("mid_exit_run",     32'(run_mode), 0);
        check_count("mid_exit_count");

        // ---- 6: wrap over several steps, then async reset mid-burst
        for (int s = 0; s < 3; s++) begin
            btn_step = 1'b1;
            tick_n(4);
            btn_step = 1'b0;
            tick_n(4);
            exp_total += 5;
            check_count("wrap_step");
        end
        btn_step = 1'b1;
        tick_n(3);
        div_bit = 1'b1;
        got_en = 1'b0;
        for (int i = 0; i < 30 && !got_en; i++) begin
            @(negedge clk);
            if (cpu_clk_en === 1'b1) got_en = 1'b1;
        end
        check("rst_mid_reach_burst", 32'(got_en), 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_mid_en",    32'(cpu_clk_en), 0);
        check("rst_mid_count", 32'(step_count), 0);
        btn_step = 1'b0;
        div_bit = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        check("rst_mid_after_en",    32'(cpu_clk_en), 0);
        check("rst_mid_after_count", 32'(step_count), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
